// File: rtl/alu_pkg.sv
// alu_seq shared definitions: ALU/M-extension op encodings and FSM states.
package alu_pkg;

    localparam int OP_M_BIT = 4;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b1000;
    localparam logic [3:0] ALU_SLL    = 4'b0001;
    localparam logic [3:0] ALU_SLT    = 4'b0010;
    localparam logic [3:0] ALU_SLTU   = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SRL    = 4'b0101;
    localparam logic [3:0] ALU_SRA    = 4'b1101;
    localparam logic [3:0] ALU_OR     = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result valid-ready bundle between the issue side and alu_seq.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 shift-add multiplier / restoring divider sharing one 2*WIDTH register.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0]   dvs;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         mode_q;
    logic               neg_q;

    logic               is_div;
    logic               sa;
    logic               sb;
    logic               neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rw;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        is_div = mode[2];
        sa = a[WIDTH-1] &
             (is_div ? ~mode[0] : (mode == M_MULH || mode == M_MULHSU));
        sb = b[WIDTH-1] & (is_div ? ~mode[0] : (mode == M_MULH));
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;
        // remainder takes the dividend's sign, everything else the xor
        neg = (is_div && mode[1]) ? sa : (sa ^ sb);
    end

    always_comb begin
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
        rw   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff = rw - {1'b0, dvs};
        if (!mode_q[2])
            acc_nx = {sum, acc[WIDTH-1:1]};
        else if (!diff[WIDTH])
            acc_nx = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_nx = {rw[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            mode_q <= '0;
            neg_q  <= 1'b0;
        end else if (start) begin
            acc    <= {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
            dvs    <= is_div ? mag_b : mag_a;
            cnt    <= CNT_W'(WIDTH);
            mode_q <= mode;
            neg_q  <= neg;
        end else if (cnt != '0) begin
            acc <= acc_nx;
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == CNT_W'(1));

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (!mode_q[2])
            result = (mode_q == M_MUL) ? prod[WIDTH-1:0]
                                       : prod[2*WIDTH-1:WIDTH];
        else
            result = mode_q[1] ? rem : quo;
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked RV32I/M execute unit: single-cycle ALU plus iterative mul/div.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] eng_res;
    logic [SH_W-1:0]  shamt;
    logic             eng_done;
    logic             eng_start;
    logic             accept;
    logic             is_m;
    logic             div_op;
    logic             b_zero;
    logic             ovf;
    logic             short_c;

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = (result_q == '0);

    assign accept    = bus.in_valid && bus.in_ready;
    assign eng_start = accept && is_m && !short_c;

    always_comb begin
        is_m    = bus.op[OP_M_BIT];
        div_op  = is_m && bus.op[2];
        b_zero  = (bus.b == '0);
        ovf     = div_op && !bus.op[0] && (bus.b == '1) &&
                  (bus.a == {1'b1, {(WIDTH-1){1'b0}}});
        short_c = div_op && (b_zero || ovf);
        shamt   = bus.b[SH_W-1:0];
        alu_res = '0;
        if (is_m) begin
            if (b_zero)
                alu_res = bus.op[1] ? bus.a : '1;
            else if (ovf)
                alu_res = bus.op[1] ? '0 : bus.a;
        end else begin
            case (bus.op[3:0])
                ALU_ADD:    alu_res = bus.a + bus.b;
                ALU_SUB:    alu_res = bus.a - bus.b;
                ALU_SLL:    alu_res = bus.a << shamt;
                ALU_SLT:    alu_res = {{(WIDTH-1){1'b0}},
                                       $signed(bus.a) < $signed(bus.b)};
                ALU_SLTU:   alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
                ALU_XOR:    alu_res = bus.a ^ bus.b;
                ALU_SRL:    alu_res = bus.a >> shamt;
                ALU_SRA:    alu_res = $unsigned($signed(bus.a) >>> shamt);
                ALU_OR:     alu_res = bus.a | bus.b;
                ALU_AND:    alu_res = bus.a & bus.b;
                ALU_PASS_B: alu_res = bus.b;
                default:    alu_res = '0;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.in_valid)
                         state_nx = short_c || !is_m ? ST_DONE : ST_BUSY;
            ST_BUSY: if (eng_done) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst)
            result_q <= '0;
        else if (accept && !eng_start)
            result_q <= alu_res;
        else if (state == ST_FIX)
            result_q <= eng_res;
    end

    muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (eng_start),
        .mode   (bus.op[2:0]),
        .a      (bus.a),
        .b      (bus.b),
        .done   (eng_done),
        .result (eng_res)
    );

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32-bit and an 8-bit instance run the same
// scenarios, each with its own hand-computed expected values.
`timescale 1ns/1ps
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    localparam logic [4:0] DIVU = {2'b10, M_DIVU};

    localparam vec_t ALU32 [13] = '{
        '{{1'b0, ALU_ADD},    32'd3,          32'd4,          32'd7},
        '{{1'b0, ALU_SUB},    32'd5,          32'd7,          32'hFFFFFFFE},
        '{{1'b0, ALU_SRA},    32'h80000000,   32'd4,          32'hF8000000},
        '{{1'b0, ALU_SLTU},   32'd1,          32'hFFFFFFFF,   32'd1},
        '{{1'b0, ALU_SLT},    32'hFFFFFFFF,   32'd1,          32'd1},
        '{{1'b0, ALU_SLL},    32'd1,          32'd31,         32'h80000000},
        '{{1'b0, ALU_SLL},    32'd1,          32'd33,         32'd2},
        '{{1'b0, ALU_SRL},    32'h80000000,   32'd31,         32'd1},
        '{{1'b0, ALU_XOR},    32'h5A5A5A5A,   32'h5A5A5A5A,   32'd0},
        '{{1'b0, ALU_OR},     32'h000000F0,   32'h0000000F,   32'h000000FF},
        '{{1'b0, ALU_AND},    32'h0000F0F0,   32'h0000FF00,   32'h0000F000},
        '{{1'b0, ALU_PASS_B}, 32'd0,          32'h12345678,   32'h12345678},
        '{5'b01001,           32'd5,          32'd3,          32'd0}
    };
    localparam vec_t ALU8 [13] = '{
        '{{1'b0, ALU_ADD},    32'd3,    32'd4,    32'd7},
        '{{1'b0, ALU_SUB},    32'd5,    32'd7,    32'hFE},
        '{{1'b0, ALU_SRA},    32'h80,   32'd4,    32'hF8},
        '{{1'b0, ALU_SLTU},   32'd1,    32'hFF,   32'd1},
        '{{1'b0, ALU_SLT},    32'hFF,   32'd1,    32'd1},
        '{{1'b0, ALU_SLL},    32'd1,    32'd7,    32'h80},
        '{{1'b0, ALU_SLL},    32'd1,    32'd9,    32'd2},
        '{{1'b0, ALU_SRL},    32'h80,   32'd7,    32'd1},
        '{{1'b0, ALU_XOR},    32'h5A,   32'h5A,   32'd0},
        '{{1'b0, ALU_OR},     32'hF0,   32'h0F,   32'hFF},
        '{{1'b0, ALU_AND},    32'hF0,   32'h3C,   32'h30},
        '{{1'b0, ALU_PASS_B}, 32'd0,    32'hAB,   32'hAB},
        '{5'b01001,           32'd5,    32'd3,    32'd0}
    };
    localparam vec_t MUL32 [6] = '{
        '{{2'b10, M_MUL},    32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1},
        '{{2'b10, M_MULHU},  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
        '{{2'b10, M_MULH},   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF},
        '{{2'b10, M_MULHSU}, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF},
        '{{2'b10, M_MULH},   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF},
        '{{2'b10, M_MULHU},  32'h80000000, 32'd4,        32'd2}
    };
    localparam vec_t MUL8 [6] = '{
        '{{2'b10, M_MUL},    32'hFF, 32'hFF, 32'h01},
        '{{2'b10, M_MULHU},  32'hFF, 32'hFF, 32'hFE},
        '{{2'b10, M_MULH},   32'hFE, 32'd3,  32'hFF},
        '{{2'b10, M_MULHSU}, 32'hFF, 32'd2,  32'hFF},
        '{{2'b10, M_MULH},   32'h7F, 32'h7F, 32'h3F},
        '{{2'b10, M_MULHU},  32'h80, 32'd4,  32'd2}
    };
    localparam vec_t DIV32 [7] = '{
        '{{2'b10, M_DIV},  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
        '{{2'b10, M_REM},  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
        '{{2'b10, M_DIVU}, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF},
        '{{2'b10, M_REMU}, 32'd100,      32'd7,        32'd2},
        '{{2'b10, M_DIV},  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD},
        '{{2'b10, M_REM},  32'd7,        32'hFFFFFFFE, 32'd1},
        '{{2'b10, M_DIVU}, 32'h80000000, 32'hFFFFFFFF, 32'd0}
    };
    localparam vec_t DIV8 [7] = '{
        '{{2'b10, M_DIV},  32'hF9,  32'd2,  32'hFD},
        '{{2'b10, M_REM},  32'hF9,  32'd2,  32'hFF},
        '{{2'b10, M_DIVU}, 32'hFF,  32'd16, 32'h0F},
        '{{2'b10, M_REMU}, 32'd100, 32'd7,  32'd2},
        '{{2'b10, M_DIV},  32'd7,   32'hFE, 32'hFD},
        '{{2'b10, M_REM},  32'd7,   32'hFE, 32'd1},
        '{{2'b10, M_DIVU}, 32'h80,  32'hFF, 32'd0}
    };
    localparam vec_t COR32 [6] = '{
        '{{2'b10, M_DIV},  32'd5,        32'd0,        32'hFFFFFFFF},
        '{{2'b10, M_REMU}, 32'd5,        32'd0,        32'd5},
        '{{2'b10, M_DIV},  32'h80000000, 32'hFFFFFFFF, 32'h80000000},
        '{{2'b10, M_REM},  32'h80000000, 32'hFFFFFFFF, 32'd0},
        '{{2'b10, M_DIVU}, 32'd5,        32'd0,        32'hFFFFFFFF},
        '{{2'b10, M_REM},  32'd9,        32'd0,        32'd9}
    };
    localparam vec_t COR8 [6] = '{
        '{{2'b10, M_DIV},  32'd5,  32'd0,  32'hFF},
        '{{2'b10, M_REMU}, 32'd5,  32'd0,  32'd5},
        '{{2'b10, M_DIV},  32'h80, 32'hFF, 32'h80},
        '{{2'b10, M_REM},  32'h80, 32'hFF, 32'd0},
        '{{2'b10, M_DIVU}, 32'd5,  32'd0,  32'hFF},
        '{{2'b10, M_REM},  32'd9,  32'd0,  32'd9}
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        w8;
    logic        in_valid;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_ready;
    logic        in_ready;
    logic        out_valid;
    logic        zero;
    logic [31:0] result;
    int          tests;
    int          fails;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) bus32 ();
    alu_seq_if #(.WIDTH(8))  bus8 ();

    alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    assign bus32.in_valid  = in_valid && !w8;
    assign bus32.op        = op;
    assign bus32.a         = a;
    assign bus32.b         = b;
    assign bus32.out_ready = out_ready;
    assign bus8.in_valid   = in_valid && w8;
    assign bus8.op         = op;
    assign bus8.a          = a[7:0];
    assign bus8.b          = b[7:0];
    assign bus8.out_ready  = out_ready;

    assign in_ready  = w8 ? bus8.in_ready  : bus32.in_ready;
    assign out_valid = w8 ? bus8.out_valid : bus32.out_valid;
    assign zero      = w8 ? bus8.zero      : bus32.zero;
    assign result    = w8 ? {24'h0, bus8.result} : bus32.result;

    // Presents one op, returns result and cycles from accept to out_valid.
    task automatic issue(input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit hold,
                         output logic [31:0] r, output int lat);
        int guard;
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        out_ready = !hold;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 200);
        r = result;
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready w8=%0d got=%b want=1", w8, in_ready);
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid w8=%0d got=%b want=0", w8, out_valid);
        end
        tests++;
        if (result !== 32'd0) begin
            fails++;
            $display("FAIL reset_result w8=%0d got=%h want=0", w8, result);
        end
        tests++;
        if (zero !== 1'b1) begin
            fails++;
            $display("FAIL reset_zero w8=%0d got=%b want=1", w8, zero);
        end
    endtask

    task automatic test_alu();
        vec_t        v;
        logic [31:0] r;
        int          lat;
        for (int i = 0; i < 13; i++) begin
            v = w8 ? ALU8[i] : ALU32[i];
            issue(v.op, v.a, v.b, 1'b0, r, lat);
            tests++;
            if (r !== v.e) begin
                fails++;
                $display("FAIL alu[%0d] w8=%0d got=%h want=%h", i, w8, r, v.e);
            end
            tests++;
            if (lat != 1) begin
                fails++;
                $display("FAIL alu_lat[%0d] w8=%0d got=%0d want=1", i, w8, lat);
            end
            tests++;
            if (zero !== (v.e == 32'd0)) begin
                fails++;
                $display("FAIL alu_zero[%0d] w8=%0d got=%b want=%b",
                         i, w8, zero, v.e == 32'd0);
            end
        end
    endtask

    task automatic test_mul();
        vec_t        v;
        logic [31:0] r;
        int          lat;
        int          elat;
        elat = w8 ? 10 : 34;
        for (int i = 0; i < 6; i++) begin
            v = w8 ? MUL8[i] : MUL32[i];
            issue(v.op, v.a, v.b, 1'b0, r, lat);
            tests++;
            if (r !== v.e) begin
                fails++;
                $display("FAIL mul[%0d] w8=%0d got=%h want=%h", i, w8, r, v.e);
            end
            tests++;
            if (lat != elat) begin
                fails++;
                $display("FAIL mul_lat[%0d] w8=%0d got=%0d want=%0d",
                         i, w8, lat, elat);
            end
        end
    endtask

    task automatic test_div();
        vec_t        v;
        logic [31:0] r;
        int          lat;
        int          elat;
        elat = w8 ? 10 : 34;
        for (int i = 0; i < 7; i++) begin
            v = w8 ? DIV8[i] : DIV32[i];
            issue(v.op, v.a, v.b, 1'b0, r, lat);
            tests++;
            if (r !== v.e) begin
                fails++;
                $display("FAIL div[%0d] w8=%0d got=%h want=%h", i, w8, r, v.e);
            end
            tests++;
            if (lat != elat) begin
                fails++;
                $display("FAIL div_lat[%0d] w8=%0d got=%0d want=%0d",
                         i, w8, lat, elat);
            end
        end
    endtask

    task automatic test_corner();
        vec_t        v;
        logic [31:0] r;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            v = w8 ? COR8[i] : COR32[i];
            issue(v.op, v.a, v.b, 1'b0, r, lat);
            tests++;
            if (r !== v.e) begin
                fails++;
                $display("FAIL corner[%0d] w8=%0d got=%h want=%h", i, w8, r, v.e);
            end
            tests++;
            if (lat != 1) begin
                fails++;
                $display("FAIL corner_lat[%0d] w8=%0d got=%0d want=1", i, w8, lat);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] r;
        int          lat;
        int          elat;
        elat = w8 ? 10 : 34;
        issue({2'b10, M_MUL}, 32'd6, 32'd7, 1'b1, r, lat);
        tests++;
        if (r !== 32'd42 || lat != elat) begin
            fails++;
            $display("FAIL bp_mul w8=%0d got=%h lat=%0d want=2a lat=%0d",
                     w8, r, lat, elat);
        end
        for (int i = 0; i < 5; i++) begin
            op = {1'b0, ALU_ADD};
            a = 32'd1;
            b = 32'd1;
            in_valid = (i == 1 || i == 2);
            @(negedge clk);
            tests++;
            if (result !== 32'd42 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_stall[%0d] w8=%0d result=%h ov=%b ir=%b want=2a 1 0",
                         i, w8, result, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release w8=%0d ir=%b ov=%b want=1 0",
                     w8, in_ready, out_valid);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || result !== 32'd42) begin
            fails++;
            $display("FAIL bp_no_accept w8=%0d ov=%b result=%h want=0 2a",
                     w8, out_valid, result);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] r;
        int          lat;
        int          redge;
        redge = w8 ? 5 : 10;
        @(negedge clk);
        op = DIVU;
        a = 32'd100;
        b = 32'd7;
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rmb_accept w8=%0d in_ready=%b want=0", w8, in_ready);
        end
        repeat (redge - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
            fails++;
            $display("FAIL rmb_state w8=%0d ov=%b ir=%b result=%h want=0 1 0",
                     w8, out_valid, in_ready, result);
        end
        issue({1'b0, ALU_ADD}, 32'd3, 32'd4, 1'b0, r, lat);
        tests++;
        if (r !== 32'd7 || lat != 1) begin
            fails++;
            $display("FAIL rmb_add w8=%0d got=%h lat=%0d want=7 lat=1", w8, r, lat);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        w8 = 1'b0;
        in_valid = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            w8 = (p == 1);
            test_reset();
            test_alu();
            test_mul();
            test_div();
            test_corner();
            test_back_pressure();
            test_reset_mid_busy();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
